// File: rtl/muldiv_sequencer_if.sv
// rtl/muldiv_sequencer_if.sv - request/response/control bundle for the multiply/divide sequencer
interface muldiv_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic [4:0]  req_rd;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        busy;

  modport master (
    output req_valid, req_op, req_rs1, req_rs2, req_rd, flush, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_rd, busy
  );

  modport slave (
    input  req_valid, req_op, req_rs1, req_rs2, req_rd, flush, resp_ready,
    output req_ready, resp_valid, resp_data, resp_rd, busy
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - multi-cycle RV32M multiply/divide sequencer
module muldiv_sequencer #(
  parameter int MUL_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  muldiv_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_op;
  logic [4:0]  r_rd;
  logic [31:0] r_opa;      // multiplicand, or dividend magnitude shifting into quotient
  logic [31:0] r_opb;      // multiplier, or divisor magnitude
  logic [32:0] r_rem;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_special;
  logic [5:0]  r_cnt;
  logic [31:0] r_data;

  // Request decode (only meaningful on the accept edge)
  logic        w_accept;
  logic        w_signed_div;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_div_zero;
  logic        w_ovf;
  logic [31:0] w_special_val;

  assign bus.req_ready  = (r_state == IDLE) && !bus.flush;
  assign bus.busy       = (r_state != IDLE);
  assign bus.resp_valid = (r_state == DONE);
  assign bus.resp_data  = r_data;
  assign bus.resp_rd    = r_rd;

  assign w_accept      = bus.req_valid && bus.req_ready;
  assign w_signed_div  = !bus.req_op[0];
  assign w_a_neg       = w_signed_div && bus.req_rs1[31];
  assign w_b_neg       = w_signed_div && bus.req_rs2[31];
  assign w_a_mag       = w_a_neg ? (~bus.req_rs1 + 32'd1) : bus.req_rs1;
  assign w_b_mag       = w_b_neg ? (~bus.req_rs2 + 32'd1) : bus.req_rs2;
  assign w_div_zero    = (bus.req_rs2 == 32'd0);
  assign w_ovf         = w_signed_div && (bus.req_rs1 == 32'h8000_0000) &&
                         (bus.req_rs2 == 32'hFFFF_FFFF);
  assign w_special_val = w_div_zero ? (bus.req_op[1] ? bus.req_rs1 : 32'hFFFF_FFFF)
                                    : (bus.req_op[1] ? 32'd0 : 32'h8000_0000);

  // Multiply: 33x33 signed product covers all signed/unsigned operand mixes
  logic               w_a_sx;
  logic               w_b_sx;
  logic signed [65:0] w_prod;
  logic [31:0]        w_mul_res;

  assign w_a_sx    = (r_op == 3'd1 || r_op == 3'd2) && r_opa[31];
  assign w_b_sx    = (r_op == 3'd1) && r_opb[31];
  assign w_prod    = $signed({w_a_sx, r_opa}) * $signed({w_b_sx, r_opb});
  assign w_mul_res = (r_op == 3'd0) ? w_prod[31:0] : w_prod[63:32];

  // Restoring division step and final sign correction
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;
  logic        w_mul_done;
  logic        w_div_done;

  assign w_shift    = {r_rem[31:0], r_opa[31]};
  assign w_ge       = (w_shift >= {1'b0, r_opb});
  assign w_q_fix    = r_neg_q ? (~r_opa + 32'd1) : r_opa;
  assign w_r_fix    = r_neg_r ? (~r_rem[31:0] + 32'd1) : r_rem[31:0];
  assign w_mul_done = (r_cnt == 6'd0);
  assign w_div_done = r_special || (r_cnt == 6'd32);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; flush overrides everything including a response handoff
  always_comb begin
    w_next = r_state;
    if (bus.flush) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: if (w_accept) w_next = bus.req_op[2] ? DIV : MUL;
        MUL:  if (w_mul_done) w_next = DONE;
        DIV:  if (w_div_done) w_next = DONE;
        DONE: if (bus.resp_ready) w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // Operand capture, iteration datapath and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op      <= 3'd0;
      r_rd      <= 5'd0;
      r_opa     <= 32'd0;
      r_opb     <= 32'd0;
      r_rem     <= 33'd0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_special <= 1'b0;
      r_cnt     <= 6'd0;
      r_data    <= 32'd0;
    end else if (r_state == IDLE) begin
      if (w_accept) begin
        r_op      <= bus.req_op;
        r_rd      <= bus.req_rd;
        r_rem     <= 33'd0;
        r_neg_q   <= w_a_neg ^ w_b_neg;
        r_neg_r   <= w_a_neg;
        r_special <= bus.req_op[2] && (w_div_zero || w_ovf);
        if (bus.req_op[2]) begin
          r_opa <= (w_div_zero || w_ovf) ? w_special_val : w_a_mag;
          r_opb <= w_b_mag;
          r_cnt <= 6'd0;
        end else begin
          r_opa <= bus.req_rs1;
          r_opb <= bus.req_rs2;
          r_cnt <= 6'(MUL_CYCLES - 1);
        end
      end
    end else if (r_state == MUL) begin
      if (w_mul_done) r_data <= w_mul_res;
      else            r_cnt  <= r_cnt - 6'd1;
    end else if (r_state == DIV) begin
      if (r_special) begin
        r_data <= r_opa;
      end else if (r_cnt == 6'd32) begin
        r_data <= r_op[1] ? w_r_fix : w_q_fix;
      end else begin
        r_rem <= w_ge ? (w_shift - {1'b0, r_opb}) : w_shift;
        r_opa <= {r_opa[30:0], w_ge};
        r_cnt <= r_cnt + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed scoreboard bench for muldiv_sequencer
module tb_muldiv_sequencer;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  muldiv_sequencer_if bus ();

  muldiv_sequencer #(.MUL_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp, input int lat);
    exp_t e;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_rs1   = a;
    bus.req_rs2   = b;
    bus.req_rd    = rd;
    e.data = exp;
    e.rd   = rd;
    e.lat  = lat;
    sb.push_back(e);
    check({tag, " req_ready"}, {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'($urandom);
    bus.req_rs1   = $urandom;
    bus.req_rs2   = $urandom;
    bus.req_rd    = 5'($urandom);
    check({tag, " busy"}, {31'd0, bus.busy}, 32'd1);
  endtask

  task automatic wait_resp(input string tag, output bit seen);
    exp_t e;
    int   n;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      seen = bus.resp_valid;
    end
    e = sb.pop_front();
    check({tag, " latency"}, seen ? n : -1, e.lat);
    if (seen) begin
      check({tag, " data"}, bus.resp_data, e.data);
      check({tag, " rd"}, {27'd0, bus.resp_rd}, {27'd0, e.rd});
    end
  endtask

  task automatic release_resp(input string tag);
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    check({tag, " idle after handoff"}, {30'd0, bus.resp_valid, bus.busy}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int lat);
    bit seen;
    start(tag, op, a, b, rd, exp, lat);
    wait_resp(tag, seen);
    if (seen) release_resp(tag);
  endtask

  task automatic quiet_window(input string tag, input int cycles);
    int hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (bus.resp_valid) hits++;
    end
    check({tag, " no response"}, hits, 32'd0);
  endtask

  initial begin
    bit          seen;
    logic [31:0] a;
    logic [31:0] b;

    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_op     = 3'd0;
    bus.req_rs1    = 32'd0;
    bus.req_rs2    = 32'd0;
    bus.req_rd     = 5'd0;
    bus.flush      = 1'b0;
    bus.resp_ready = 1'b0;
    #1;
    check("reset resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("reset resp_data", bus.resp_data, 32'd0);
    check("reset resp_rd", {27'd0, bus.resp_rd}, 32'd0);
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset req_ready", {31'd0, bus.req_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Normal division
    run_op("DIV 100/7", 3'd4, 32'd100, 32'd7, 5'd1, 32'd14, 33);
    run_op("REM 100%7", 3'd6, 32'd100, 32'd7, 5'd2, 32'd2, 33);
    run_op("DIVU ffffffff/16", 3'd5, 32'hFFFF_FFFF, 32'd16, 5'd3, 32'h0FFF_FFFF, 33);
    run_op("DIV -7/2", 3'd4, -32'sd7, 32'd2, 5'd4, 32'hFFFF_FFFD, 33);
    run_op("REM -7%2", 3'd6, -32'sd7, 32'd2, 5'd5, 32'hFFFF_FFFF, 33);
    run_op("DIV 7/-2", 3'd4, 32'd7, -32'sd2, 5'd6, 32'hFFFF_FFFD, 33);
    run_op("REM 7%-2", 3'd6, 32'd7, -32'sd2, 5'd7, 32'd1, 33);
    run_op("DIVU 80000000/ffffffff", 3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'd0, 33);
    run_op("REMU 80000000%ffffffff", 3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000, 33);

    // Divide-by-zero and signed overflow shortcuts
    run_op("DIVU 9/0", 3'd5, 32'd9, 32'd0, 5'd10, 32'hFFFF_FFFF, 1);
    run_op("REMU 5%0", 3'd7, 32'd5, 32'd0, 5'd11, 32'd5, 1);
    run_op("DIV 5/0", 3'd4, 32'd5, 32'd0, 5'd12, 32'hFFFF_FFFF, 1);
    run_op("REM -5%0", 3'd6, -32'sd5, 32'd0, 5'd13, 32'hFFFF_FFFB, 1);
    run_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1);
    run_op("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0, 1);

    // Multiply variants
    run_op("MUL -1*-1", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd16, 32'd1, 2);
    run_op("MULH -1*-1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, 32'd0, 2);
    run_op("MULHU max*max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd18, 32'hFFFF_FFFE, 2);
    run_op("MULHSU -1*max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd19, 32'hFFFF_FFFF, 2);
    run_op("MUL rd0", 3'd0, 32'd3, 32'd4, 5'd0, 32'd12, 2);

    // Random unsigned division against the bench's own arithmetic
    for (int i = 0; i < 3; i++) begin
      a = $urandom;
      b = $urandom_range(1, 5000);
      run_op("DIVU rand", 3'd5, a, b, 5'(20 + i), a / b, 33);
      run_op("REMU rand", 3'd7, a, b, 5'(24 + i), a % b, 33);
    end

    // Back-pressure: result held while resp_ready is low, new requests ignored
    start("hold", 3'd0, 32'd6, 32'd7, 5'd9, 32'd42, 2);
    wait_resp("hold", seen);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd0;
    bus.req_rs1   = 32'd1;
    bus.req_rs2   = 32'd1;
    bus.req_rd    = 5'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold resp_valid", {31'd0, bus.resp_valid}, 32'd1);
      check("hold resp_data", bus.resp_data, 32'd42);
      check("hold resp_rd", {27'd0, bus.resp_rd}, 32'd9);
      check("hold busy/req_ready", {30'd0, bus.busy, bus.req_ready}, 32'd2);
    end
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("handoff no same-edge accept", {30'd0, bus.busy, bus.resp_valid}, 32'd0);
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b0;

    // Flush at division iteration 10
    start("flush", 3'd4, 32'd100, 32'd7, 5'd3, 32'd14, 33);
    void'(sb.pop_back());
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    check("flush idle", {30'd0, bus.busy, bus.resp_valid}, 32'd0);
    check("flush req_ready low", {31'd0, bus.req_ready}, 32'd0);
    bus.flush = 1'b0;
    #1;
    check("flush req_ready", {31'd0, bus.req_ready}, 32'd1);
    quiet_window("flush", 40);

    // Flush and resp_ready together in DONE: result dropped
    start("flush in DONE", 3'd0, 32'd2, 32'd3, 5'd4, 32'd6, 2);
    wait_resp("flush in DONE", seen);
    @(negedge clk);
    bus.flush      = 1'b1;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("flush in DONE idle", {30'd0, bus.busy, bus.resp_valid}, 32'd0);
    bus.flush      = 1'b0;
    bus.resp_ready = 1'b0;

    // Reset mid-division; previous result left resp_data/resp_rd non-zero
    start("reset", 3'd4, 32'd1000, 32'd3, 5'd30, 32'd333, 33);
    void'(sb.pop_back());
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("reset mid resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("reset mid resp_data", bus.resp_data, 32'd0);
    check("reset mid resp_rd", {27'd0, bus.resp_rd}, 32'd0);
    check("reset mid busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    quiet_window("reset", 40);

    run_op("post-reset DIV", 3'd4, 32'd1000, 32'd3, 5'd31, 32'd333, 33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 2, cycles from request accept to multiply result valid; legal range 1..4.
REQ-002 SHALL have port clk  input  1  single clock for all state; rising edge active.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  request present.
REQ-005 SHALL have port req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-006 SHALL have port req_op  input  3  operation code: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 SHALL have port req_rs1  input  32  operand A.
REQ-008 SHALL have port req_rs2  input  32  operand B.
REQ-009 SHALL have port req_rd  input  5  destination register tag.
REQ-010 SHALL have port flush  input  1  abort any in-flight operation.
REQ-011 SHALL have port resp_valid  output  1  result present.
REQ-012 SHALL have port resp_ready  input  1  consumer accepts result.
REQ-013 SHALL have port resp_data  output  32  result value.
REQ-014 SHALL have port resp_rd  output  5  destination tag of result.
REQ-015 SHALL have port busy  output  1  pipeline stall request.

Function
REQ-016 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-017 SHALL drive req_ready = (state==IDLE) && !flush.
REQ-018 SHALL accept on the edge where req_valid && req_ready, latching op, operands and rd.
REQ-019 SHALL drive busy = (state!=IDLE).
REQ-020 SHALL, for MUL ops, enter DONE exactly MUL_CYCLES edges after accept. MUL returns product[31:0]. MULH, MULHSU and MULHU return product[63:32] of signed*signed, signed*unsigned and unsigned*unsigned respectively.
REQ-021 SHALL, for DIV/REM ops with rs2==0, enter DONE 1 edge after accept with these results: DIV/DIVU 0xFFFFFFFF, REM/REMU rs1.
REQ-022 SHALL, for DIV/REM with rs1==0x80000000 and rs2==0xFFFFFFFF, enter DONE 1 edge after accept with these results: DIV 0x80000000, REM 0.
REQ-023 SHALL otherwise perform 32-iteration restoring unsigned division on operand magnitudes (magnitudes for signed ops, raw values for unsigned ops), one quotient bit per cycle, using a 6-bit iteration counter.
REQ-024 SHALL apply sign correction on the final cycle: quotient negated when operand signs differ (signed ops only); remainder takes the sign of rs1; DONE entered 33 edges after accept.
REQ-025 SHALL assert resp_valid only in DONE, holding resp_data/resp_rd stable until resp_ready.
REQ-026 SHALL transition DONE->IDLE on the edge with resp_ready high; no new request is accepted on that same edge.
REQ-027 SHALL, on flush high at an edge in any state, go to IDLE, discard the result, and deassert resp_valid the following cycle.
REQ-028 SHALL treat flush and resp_ready both high in DONE as flush (result dropped, IDLE).
REQ-029 SHALL ignore req_valid while not IDLE; operand inputs need not be held after accept.
REQ-030 SHALL compute and return results for req_rd==0 like any other tag.

Reset
REQ-031 SHALL, on rst high, asynchronously force state=IDLE, resp_valid=0, resp_data=0, resp_rd=0, counter=0, busy=0. req_ready is 1 when flush is low.
REQ-032 SHALL abandon any in-flight operation on reset mid-operation; no response is produced after reset release.

Verification
REQ-033 SHALL cover: DIV 100,7 -> resp_valid at edge 33, data 14. REM 100,7 -> data 2. DIVU 0xFFFFFFFF,16 -> 0x0FFFFFFF.
REQ-034 SHALL cover: DIV -7,2 -> 0xFFFFFFFD. REM -7,2 -> 0xFFFFFFFF. DIV 7,-2 -> 0xFFFFFFFD. REM 7,-2 -> 1.
REQ-035 SHALL cover: DIVU 9,0 -> 0xFFFFFFFF at edge 1. REMU 5,0 -> 5. DIV 0x80000000,0xFFFFFFFF -> 0x80000000 at edge 1. REM same operands -> 0.
REQ-036 SHALL cover, MUL_CYCLES=2: MUL 0xFFFFFFFF,0xFFFFFFFF -> 1. MULH same -> 0. MULHU same -> 0xFFFFFFFE. MULHSU same -> 0xFFFFFFFF. All at edge 2.
REQ-037 SHALL cover: resp_ready low 5 cycles in DONE -> resp_valid/data held, busy=1, req_ready=0. Then resp_ready high -> IDLE next edge.
REQ-038 SHALL cover: flush at DIV iteration 10 -> IDLE next edge, no resp_valid. rst mid-DIV -> outputs zero immediately, no response after release.
